alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised successor to the datapath ALU and status-flag logic. It is a WIDTH-bit execution unit with a start/done handshake. Single-cycle ops (add, sub, and, or, negate, pass) sit alongside multi-cycle ops (unsigned shift-add multiply, arithmetic shift right), and flags are held in registers. The unit sits between the X/Y operand registers and the Z bus, and drives the branch-condition bit for the control unit.

## Interface
Parameters:
- WIDTH, 16, datapath width; legal range 4..64. SHW = clog2(WIDTH) is derived.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 NEG, 110 PASS x, 111 ASR
- x, y  in  WIDTH  operands; sampled on the accepting edge
- flag_en  in  1  sampled with start; 1 = update flags on completion
- cond  in  4  condition select; same encoding as the existing Dcondn mux
- busy  out  1  high while a multi-cycle op is running
- done  out  1  one-cycle pulse; z and flags are valid from the same edge
- z  out  WIDTH  registered result; holds until the next completion
- flags  out  4  {S,V,C,Z}, registered
- dcondn  out  1  combinational from flags and cond

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Transitions from IDLE on start=1 (x, y, op and flag_en captured internally):
  - Single-cycle op, or ASR with y[SHW-1:0]=0: z written on the accepting edge, done=1 for the following cycle, state stays IDLE.
  - MUL: go to RUN with counter=WIDTH.
  - ASR with shamt>0: go to RUN with counter=shamt.
- RUN: one iteration per cycle, counter decrements. The edge on which counter reaches 0 writes z, asserts done, and returns to IDLE.
- Start while busy=1 is ignored; no queueing. Input changes during RUN have no effect.
- Arithmetic (all modulo 2^WIDTH):
  - ADD: x+y.
  - SUB: x+~y+1.
  - NEG: ~x+1.
- MUL: unsigned shift-add over a 2*WIDTH accumulator; z = low WIDTH bits.
- ASR: one bit per cycle, sign bit replicated.
- Flags (loaded only at completion, and only if captured flag_en=1; otherwise held):
  - Z = (z==0); S = z[WIDTH-1].
  - ADD/SUB/NEG: C = carry out of the MSB (SUB: 1 = no borrow); V = carry into MSB xor carry out.
  - MUL: C=0; V=1 iff the high WIDTH bits of the product are nonzero.
  - ASR: C = last bit shifted out (0 if shamt=0); V=0.
  - AND/OR/PASS: C=0, V=0.
- dcondn by cond:
  - 0000 → 1
  - 1000 → Z, 1001 → !Z
  - 1010 → C, 1011 → !C
  - 1100 → V, 1101 → !V
  - 1110 → S, 1111 → !S
  - any other code → 0
- Reset (rst=1 at an edge):
  - state IDLE; z=0, flags=0, busy=0, done=0, counter=0.
  - An in-flight op is aborted with no done.
  - rst takes priority over start in the same cycle.

## Timing
- Single-cycle ops: latency 1; done is high in the cycle after the accepting edge.
- Back-to-back single-cycle ops: one per cycle (start may be high while done=1).
- MUL: busy high for exactly WIDTH cycles; done rises on the edge where busy falls.
- ASR: latency max(1, shamt) cycles.
- A new start is accepted in the done cycle because busy=0 there.
- dcondn has no added latency relative to flags.

## Test plan
1. Reset:
   - rst=1 for 2 cycles → z=0, flags=0, busy=0, done=0.
   - cond=0000 → dcondn=1; cond=1000 → dcondn=0.
2. ADD x=0x7FFF, y=0x0001, flag_en=1 → next cycle z=0x8000, done=1, {S,V,C,Z}=1100; cond=1100 → dcondn=1.
3. SUB:
   - x=5, y=5 → z=0, Z=1, C=1.
   - Then NEG x=0x0002 → z=0xFFFE, S=1.
   - Then AND with flag_en=0 → flags unchanged.
4. MUL x=300, y=300 (WIDTH=16):
   - busy for 16 cycles, done on the 16th edge, z=0x5F90, V=1.
   - A start with op=ADD pulsed mid-run is ignored.
5. ASR:
   - x=0x8000, y=3 → z=0xF000 after 3 cycles, C=0.
   - x=0x0005, y=1 → z=0x0002, C=1.
   - y=0 → z=x in 1 cycle.
6. rst asserted at cycle 5 of a MUL → busy=0 and z=0 next cycle, no done pulse; a following ADD 2+3 → z=5 normally.

Source files
------------

// File: rtl/alu_seq_unit.sv
// WIDTH-bit execution unit: single-cycle ADD/SUB/AND/OR/NEG/PASS, iterative shift-add MUL and ASR.
// Latency: 1 cycle for single-cycle ops; WIDTH cycles for MUL; max(1,shamt) cycles for ASR.
// No backpressure: start is taken only while busy=0; a start seen while busy is dropped, never queued.
module alu_seq_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             flag_en,
   input  logic [3:0]       cond,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic [3:0]       flags,
   output logic             dcondn
);
   localparam int SHW = $clog2(WIDTH);
   // One extra bit so the counter can hold WIDTH itself for MUL.
   localparam int CW  = SHW + 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_NEG  = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;
   localparam logic [2:0] OP_ASR  = 3'b111;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   acc_q;     // MUL: {partial sum, multiplier}; ASR: low half is the shifting value
   logic [WIDTH-1:0]     x_q;       // captured multiplicand
   logic                 mul_q;     // 1 = running MUL, 0 = running ASR
   logic                 fen_q;     // captured flag_en
   logic [WIDTH-1:0]     z_q;
   logic [3:0]           flags_q;   // {S,V,C,Z}
   logic                 done_q;

   logic [WIDTH-1:0]     add_a, add_b;
   logic                 add_cin;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH-1:0]     sc_res;
   logic                 sc_c, sc_v;
   logic [3:0]           sc_flg;

   logic [WIDTH-1:0]     mul_add;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH-1:0]     asr_nxt;
   logic [2*WIDTH-1:0]   acc_d;
   logic [WIDTH-1:0]     run_res;
   logic                 run_c, run_v;
   logic [3:0]           run_flg;

   logic [SHW-1:0]       shamt;
   assign shamt = y[SHW-1:0];

   // Single-cycle result and flags, computed straight from the live operands on the accepting edge.
   always_comb begin
      add_a   = x;
      add_b   = y;
      add_cin = 1'b0;
      case (op)
         OP_SUB:  begin add_b = ~y; add_cin = 1'b1; end
         OP_NEG:  begin add_a = ~x; add_b = '0; add_cin = 1'b1; end
         default: ;
      endcase
      add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
      sc_res  = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_NEG: begin
            sc_res = add_sum[WIDTH-1:0];
            sc_c   = add_sum[WIDTH];
            // carry into MSB xor carry out of MSB
            sc_v   = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1] ^ add_sum[WIDTH];
         end
         OP_AND:           sc_res = x & y;
         OP_OR:            sc_res = x | y;
         OP_PASS, OP_ASR:  sc_res = x;   // ASR only lands here with shamt=0
         default:          ;
      endcase
      sc_flg = {sc_res[WIDTH-1], sc_v, sc_c, (sc_res == '0)};
   end

   // One iteration of the running multi-cycle op, plus the result/flags if this is the last one.
   always_comb begin
      mul_add = acc_q[0] ? x_q : {WIDTH{1'b0}};
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
      asr_nxt = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      if (mul_q) begin
         acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
         run_res = acc_d[WIDTH-1:0];
         run_c   = 1'b0;
         run_v   = |acc_d[2*WIDTH-1:WIDTH];
      end else begin
         acc_d   = {acc_q[2*WIDTH-1:WIDTH], asr_nxt};
         run_res = asr_nxt;
         run_c   = acc_q[0];   // bit shifted out on this final step
         run_v   = 1'b0;
      end
      run_flg = {run_res[WIDTH-1], run_v, run_c, (run_res == '0)};
   end

   // Control FSM with registered result, flags and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         mul_q   <= 1'b0;
         fen_q   <= 1'b0;
         z_q     <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  fen_q <= flag_en;
                  if (op == OP_MUL) begin
                     acc_q   <= {{WIDTH{1'b0}}, y};
                     x_q     <= x;
                     mul_q   <= 1'b1;
                     cnt_q   <= CW'(WIDTH);
                     state_q <= RUN;
                  end else if (op == OP_ASR && shamt != '0) begin
                     acc_q   <= {{WIDTH{1'b0}}, x};
                     mul_q   <= 1'b0;
                     cnt_q   <= CW'(shamt);
                     state_q <= RUN;
                  end else begin
                     z_q    <= sc_res;
                     done_q <= 1'b1;
                     if (flag_en) flags_q <= sc_flg;
                  end
               end
            end
            RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  z_q     <= run_res;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
                  if (fen_q) flags_q <= run_flg;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Branch condition decode from the registered flags.
   always_comb begin
      case (cond)
         4'b0000: dcondn = 1'b1;
         4'b1000: dcondn = flags_q[0];
         4'b1001: dcondn = ~flags_q[0];
         4'b1010: dcondn = flags_q[1];
         4'b1011: dcondn = ~flags_q[1];
         4'b1100: dcondn = flags_q[2];
         4'b1101: dcondn = ~flags_q[2];
         4'b1110: dcondn = flags_q[3];
         4'b1111: dcondn = ~flags_q[3];
         default: dcondn = 1'b0;
      endcase
   end

   assign busy  = (state_q == RUN);
   assign done  = done_q;
   assign z     = z_q;
   assign flags = flags_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=16.
module tb_alu_seq_unit;
   logic        clk = 1'b0;
   logic        rst, start, flag_en;
   logic [2:0]  op;
   logic [15:0] x, y;
   logic [3:0]  cond;
   logic        busy, done, dcondn;
   logic [15:0] z;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   alu_seq_unit #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
      .flag_en(flag_en), .cond(cond), .busy(busy), .done(done),
      .z(z), .flags(flags), .dcondn(dcondn)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 3'b000; x = '0; y = '0; flag_en = 1'b0; cond = 4'b0000;
      step(); step();
      rst = 1'b0;
      checks++; if (z !== 16'h0000) begin errors++; $display("FAIL reset_z got %h want 0000", z); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      cond = 4'b0000; #1;
      checks++; if (dcondn !== 1'b1) begin errors++; $display("FAIL reset_cond0000 got %b want 1", dcondn); end
      cond = 4'b1000; #1;
      checks++; if (dcondn !== 1'b0) begin errors++; $display("FAIL reset_cond1000 got %b want 0", dcondn); end
   endtask

   task automatic test_add();
      start = 1'b1; op = 3'b000; x = 16'h7FFF; y = 16'h0001; flag_en = 1'b1;
      step();
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", done); end
      checks++; if (z !== 16'h8000) begin errors++; $display("FAIL add_z got %h want 8000", z); end
      checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL add_flags got %b want 1100", flags); end
      cond = 4'b1100; #1;
      checks++; if (dcondn !== 1'b1) begin errors++; $display("FAIL add_cond_v got %b want 1", dcondn); end
      cond = 4'b1011; #1;
      checks++; if (dcondn !== 1'b1) begin errors++; $display("FAIL add_cond_nc got %b want 1", dcondn); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
   endtask

   task automatic test_sub_neg_and();
      start = 1'b1; op = 3'b001; x = 16'd5; y = 16'd5; flag_en = 1'b1;
      step();
      checks++; if (z !== 16'h0000) begin errors++; $display("FAIL sub_z got %h want 0000", z); end
      checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL sub_flags got %b want 0011", flags); end
      cond = 4'b1000; #1;
      checks++; if (dcondn !== 1'b1) begin errors++; $display("FAIL sub_cond_z got %b want 1", dcondn); end
      op = 3'b101; x = 16'h0002; y = 16'h0000;
      step();
      checks++; if (z !== 16'hFFFE) begin errors++; $display("FAIL neg_z got %h want fffe", z); end
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL neg_flags got %b want 1000", flags); end
      op = 3'b010; x = 16'h00F0; y = 16'h0FF0; flag_en = 1'b0;
      step();
      start = 1'b0;
      checks++; if (z !== 16'h00F0) begin errors++; $display("FAIL and_z got %h want 00f0", z); end
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL and_flags_held got %b want 1000", flags); end
      step();
   endtask

   task automatic test_mul();
      int n;
      start = 1'b1; op = 3'b100; x = 16'd300; y = 16'd300; flag_en = 1'b1;
      step();
      start = 1'b0; x = 16'hAAAA; y = 16'h5555;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (n == 5) begin start = 1'b1; op = 3'b000; x = 16'd1; y = 16'd1; end
         else start = 1'b0;
         if (n == 6) begin
            checks++; if (done !== 1'b0 || z !== 16'h00F0) begin errors++; $display("FAIL mul_midrun_ignore got done=%b z=%h want done=0 z=00f0", done, z); end
         end
         step();
         n++;
      end
      start = 1'b0;
      checks++; if (n !== 16) begin errors++; $display("FAIL mul_busy_cycles got %0d want 16", n); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done got %b want 1", done); end
      checks++; if (z !== 16'h5F90) begin errors++; $display("FAIL mul_z got %h want 5f90", z); end
      checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL mul_flags got %b want 0100", flags); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", done); end
   endtask

   task automatic test_asr();
      int n;
      start = 1'b1; op = 3'b111; x = 16'h8000; y = 16'd3; flag_en = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL asr3_cycles got %0d want 3", n); end
      checks++; if (z !== 16'hF000 || done !== 1'b1) begin errors++; $display("FAIL asr3_z got %h done=%b want f000 done=1", z, done); end
      checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL asr3_flags got %b want 1000", flags); end
      start = 1'b1; x = 16'h0005; y = 16'd1;
      step();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      checks++; if (n !== 1) begin errors++; $display("FAIL asr1_cycles got %0d want 1", n); end
      checks++; if (z !== 16'h0002) begin errors++; $display("FAIL asr1_z got %h want 0002", z); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL asr1_flags got %b want 0010", flags); end
      start = 1'b1; x = 16'h1234; y = 16'h0010;   // low 4 bits zero -> shamt 0
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL asr0_hs got busy=%b done=%b want 0 1", busy, done); end
      checks++; if (z !== 16'h1234) begin errors++; $display("FAIL asr0_z got %h want 1234", z); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL asr0_flags got %b want 0000", flags); end
      step();
   endtask

   task automatic test_back_to_back();
      start = 1'b1; op = 3'b000; x = 16'd1; y = 16'd2; flag_en = 1'b1;
      step();
      checks++; if (z !== 16'd3 || done !== 1'b1) begin errors++; $display("FAIL b2b_first got z=%h done=%b want 0003 1", z, done); end
      op = 3'b011; x = 16'h0F00; y = 16'h00F0;
      step();
      start = 1'b0;
      checks++; if (z !== 16'h0FF0 || done !== 1'b1) begin errors++; $display("FAIL b2b_second got z=%h done=%b want 0ff0 1", z, done); end
      step();
      checks++; if (done !== 1'b0 || z !== 16'h0FF0) begin errors++; $display("FAIL b2b_hold got z=%h done=%b want 0ff0 0", z, done); end
   endtask

   task automatic test_reset_abort();
      start = 1'b1; op = 3'b100; x = 16'd7; y = 16'd9; flag_en = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
      rst = 1'b1; start = 1'b1;   // reset wins over a simultaneous start
      step();
      rst = 1'b0; start = 1'b0;
      checks++; if (busy !== 1'b0 || z !== 16'h0000 || done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b z=%h done=%b want 0 0000 0", busy, z, done); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL abort_flags got %b want 0000", flags); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done got done=%b busy=%b want 0 0", done, busy); end
      start = 1'b1; op = 3'b000; x = 16'd2; y = 16'd3;
      step();
      start = 1'b0;
      checks++; if (z !== 16'd5 || done !== 1'b1) begin errors++; $display("FAIL abort_add got z=%h done=%b want 0005 1", z, done); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL abort_add_flags got %b want 0000", flags); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_neg_and();
      test_mul();
      test_asr();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
